uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx_if.sv | 12 +
 rtl/uart_rx.sv | 145 ++++++++++++++
 tb/tb_uart_rx.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Receive-side result bundle of the UART receiver: received byte, status pulses, busy flag.
// Latency: none; this is only a signal grouping.
// Backpressure: none; the consumer must catch rd_valid/frame_err pulses when they occur.
interface uart_rx_if;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       frame_err;
    logic       busy;

    modport master (output rd_data, output rd_valid, output frame_err, output busy);
    modport slave  (input  rd_data, input  rd_valid, input  frame_err, input  busy);
endinterface

// File: rtl/uart_rx.sv
// 8-N-1 UART receiver with 16x oversampling and 2-of-3 majority voting at ticks 8..10.
// Latency: rd_valid is registered, asserting on the clock after tick 154 following start-edge detection.
// Backpressure: none; rd_data is overwritten by each new good frame, and pulses are not held.
module uart_rx #(
    parameter int unsigned CLK_HZ = 100_000_000,
    parameter int unsigned BAUD   = 9600
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     rxd,
    uart_rx_if.master rx_if
);
    localparam int unsigned DIV16 = (CLK_HZ + 8 * BAUD) / (16 * BAUD);
    localparam int unsigned DIV_W = (DIV16 > 1) ? $clog2(DIV16) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV16 - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t           state_q, state_d;
    logic             rxd_meta_q, rxd_sync_q, rxd_prev_q;
    logic [DIV_W-1:0] div_q, div_d;
    logic [3:0]       tick_q, tick_d;       // ticks already elapsed in the current bit
    logic [2:0]       bit_q, bit_d;
    logic [1:0]       samp_q, samp_d;       // [1] = tick-8 sample, [0] = tick-9 sample
    logic [7:0]       shreg_q, shreg_d;
    logic [7:0]       rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic             frame_err_q, frame_err_d;

    logic             start_edge;
    logic             tick;
    logic [4:0]       tick_num;
    logic             maj;

    assign start_edge = rxd_prev_q & ~rxd_sync_q;
    assign tick       = (state_q != S_IDLE) && (div_q == DIV_LAST);
    assign tick_num   = {1'b0, tick_q} + 5'd1;
    // tick-10 sample is the live synchronized value, voted against the two stored ones
    assign maj        = (samp_q[1] & samp_q[0]) | (samp_q[1] & rxd_sync_q) | (samp_q[0] & rxd_sync_q);

    // Two-flop synchronizer plus edge history; all reset to the idle-line level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_meta_q <= 1'b1;
            rxd_sync_q <= 1'b1;
            rxd_prev_q <= 1'b1;
        end else begin
            rxd_meta_q <= rxd;
            rxd_sync_q <= rxd_meta_q;
            rxd_prev_q <= rxd_sync_q;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next state, oversample counters, shift register and output pulses
    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        tick_d      = tick_q;
        bit_d       = bit_q;
        samp_d      = samp_q;
        shreg_d     = shreg_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = 1'b0;
        frame_err_d = 1'b0;

        if (state_q == S_IDLE) begin
            // Counters held clear so tick 1 lands exactly DIV16 clocks after the edge
            div_d  = '0;
            tick_d = '0;
            bit_d  = '0;
        end else begin
            div_d = tick ? '0 : div_q + DIV_W'(1);
            if (tick) begin
                tick_d = tick_q + 4'd1;   // wraps to 0 after tick 16
                if (tick_num == 5'd8) samp_d[1] = rxd_sync_q;
                if (tick_num == 5'd9) samp_d[0] = rxd_sync_q;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start_edge) state_d = S_START;
            end
            S_START: begin
                if (tick && tick_num == 5'd10 && maj) state_d = S_IDLE;   // glitch, not a start bit
                else if (tick && tick_num == 5'd16)   state_d = S_DATA;
            end
            S_DATA: begin
                if (tick && tick_num == 5'd10) shreg_d = {maj, shreg_q[7:1]};
                if (tick && tick_num == 5'd16) begin
                    if (bit_q == 3'd7) state_d = S_STOP;
                    else               bit_d   = bit_q + 3'd1;
                end
            end
            S_STOP: begin
                // Leave at mid stop bit to leave margin for a back-to-back start edge
                if (tick && tick_num == 5'd10) begin
                    if (maj) begin
                        rd_data_d  = shreg_q;
                        rd_valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q       <= '0;
            tick_q      <= '0;
            bit_q       <= '0;
            samp_q      <= '0;
            shreg_q     <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            div_q       <= div_d;
            tick_q      <= tick_d;
            bit_q       <= bit_d;
            samp_q      <= samp_d;
            shreg_q     <= shreg_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign rx_if.rd_data   = rd_data_q;
    assign rx_if.rd_valid  = rd_valid_q;
    assign rx_if.frame_err = frame_err_q;
    assign rx_if.busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with a pulse scoreboard checked by an independent monitor.
// Bit period scaled down to 128 clocks (DIV16 = 8) to keep runtime short.
// Expected pulses are queued at stimulus time and popped whenever the DUT pulses.
module tb_uart_rx;
    localparam int unsigned CLK_HZ = 12_800_000;
    localparam int unsigned BAUD   = 100_000;
    localparam int          BIT    = 128;          // clocks per bit: 16 * DIV16, DIV16 = 8
    localparam int          LAT    = 154 * 8 + 3;  // drive-to-rd_valid: 2 sync flops + edge stage

    typedef struct packed {
        logic       err;
        logic [7:0] data;
    } exp_t;

    logic clk;
    logic rst_n;
    logic rxd;

    uart_rx_if rx_if ();

    uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rxd   (rxd),
        .rx_if (rx_if)
    );

    exp_t        exp_q[$];
    int          n_tests   = 0;
    int          n_fail    = 0;
    int          n_valid   = 0;
    int          exp_valid = 0;
    int          cyc       = 0;
    int          lat_start = 0;
    bit          lat_arm   = 0;
    logic [7:0]  last_good = 8'h00;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_good(input logic [7:0] d);
        exp_q.push_back({1'b0, d});
        last_good = d;
        exp_valid++;
    endtask

    task automatic expect_ferr();
        exp_q.push_back({1'b1, last_good});
    endtask

    // Transmit one 8-N-1 frame; stop_bit lets the caller corrupt the framing
    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int per);
        rxd = 1'b0;
        wait_cyc(per);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            wait_cyc(per);
        end
        rxd = stop_bit;
        wait_cyc(per);
    endtask

    // Monitor: every output pulse must match the head of the scoreboard
    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_if.rd_valid && rx_if.frame_err)
                chk("valid_and_ferr_together", 32'd1, 32'd0);
            if (rx_if.rd_valid || rx_if.frame_err) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_pulse: rd_valid=%0b frame_err=%0b rd_data=0x%0h, expected no pulse",
                             rx_if.rd_valid, rx_if.frame_err, rx_if.rd_data);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("pulse_is_frame_err", {31'd0, rx_if.frame_err}, {31'd0, e.err});
                    chk("rd_data_at_pulse", {24'd0, rx_if.rd_data}, {24'd0, e.data});
                end
                if (rx_if.rd_valid) begin
                    n_valid++;
                    if (lat_arm) begin
                        chk("rd_valid_latency", cyc - lat_start, LAT);
                        lat_arm = 0;
                    end
                end
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        rxd   = 1'b1;
        wait_cyc(5);
        chk("reset_rd_data",   {24'd0, rx_if.rd_data}, 32'h00);
        chk("reset_rd_valid",  {31'd0, rx_if.rd_valid}, 32'd0);
        chk("reset_frame_err", {31'd0, rx_if.frame_err}, 32'd0);
        chk("reset_busy",      {31'd0, rx_if.busy}, 32'd0);
        rst_n = 1'b1;
        wait_cyc(20);
        chk("idle_after_release_busy", {31'd0, rx_if.busy}, 32'd0);

        // Single good frame with exact pulse latency
        expect_good(8'hA5);
        lat_start = cyc;
        lat_arm   = 1;
        send_frame(8'hA5, 1'b1, BIT);
        wait_cyc(2 * BIT);
        chk("a5_busy_after", {31'd0, rx_if.busy}, 32'd0);
        chk("a5_rd_data_held", {24'd0, rx_if.rd_data}, 32'hA5);

        // False start: short low glitch, busy must drop exactly at tick 10
        rxd = 1'b0;
        wait_cyc(10);
        chk("false_start_busy_high", {31'd0, rx_if.busy}, 32'd1);
        wait_cyc(15);
        rxd = 1'b1;
        wait_cyc(57);
        chk("false_start_busy_before_tick10", {31'd0, rx_if.busy}, 32'd1);
        wait_cyc(1);
        chk("false_start_busy_after_tick10", {31'd0, rx_if.busy}, 32'd0);
        wait_cyc(2 * BIT);

        // Framing error, line left low: no restart until it goes high then falls
        expect_ferr();
        send_frame(8'h3C, 1'b0, BIT);
        wait_cyc(3 * BIT);
        chk("ferr_line_low_no_restart", {31'd0, rx_if.busy}, 32'd0);
        chk("ferr_rd_data_kept", {24'd0, rx_if.rd_data}, 32'hA5);
        rxd = 1'b1;
        wait_cyc(2 * BIT);

        // Back-to-back frames, transmitter slow then fast
        expect_good(8'h00);
        expect_good(8'hFF);
        expect_good(8'h55);
        send_frame(8'h00, 1'b1, 130);
        send_frame(8'hFF, 1'b1, 130);
        send_frame(8'h55, 1'b1, 130);
        wait_cyc(2 * BIT);
        expect_good(8'h00);
        expect_good(8'hFF);
        expect_good(8'h55);
        send_frame(8'h00, 1'b1, 126);
        send_frame(8'hFF, 1'b1, 126);
        send_frame(8'h55, 1'b1, 126);
        wait_cyc(2 * BIT);
        chk("b2b_last_rd_data", {24'd0, rx_if.rd_data}, 32'h55);

        // Reset in the middle of bit 4 aborts the frame
        rxd = 1'b0;
        wait_cyc(BIT);
        for (int i = 0; i < 4; i++) begin
            rxd = 1'b1;
            wait_cyc(BIT);
        end
        rxd = 1'b0;
        wait_cyc(BIT / 2);
        chk("mid_frame_busy", {31'd0, rx_if.busy}, 32'd1);
        rst_n = 1'b0;
        rxd   = 1'b1;
        wait_cyc(5);
        chk("midrst_rd_data",   {24'd0, rx_if.rd_data}, 32'h00);
        chk("midrst_busy",      {31'd0, rx_if.busy}, 32'd0);
        chk("midrst_rd_valid",  {31'd0, rx_if.rd_valid}, 32'd0);
        chk("midrst_frame_err", {31'd0, rx_if.frame_err}, 32'd0);
        rst_n     = 1'b1;
        last_good = 8'h00;
        wait_cyc(10 * BIT);
        chk("post_reset_idle_busy", {31'd0, rx_if.busy}, 32'd0);
        expect_good(8'h81);
        send_frame(8'h81, 1'b1, BIT);
        wait_cyc(2 * BIT);
        chk("post_reset_rd_data", {24'd0, rx_if.rd_data}, 32'h81);

        // Assorted back-to-back patterns at nominal rate
        expect_good(8'h01);
        expect_good(8'h80);
        expect_good(8'h7E);
        expect_good(8'hC3);
        expect_good(8'h10);
        send_frame(8'h01, 1'b1, BIT);
        send_frame(8'h80, 1'b1, BIT);
        send_frame(8'h7E, 1'b1, BIT);
        send_frame(8'hC3, 1'b1, BIT);
        send_frame(8'h10, 1'b1, BIT);
        wait_cyc(3 * BIT);

        chk("scoreboard_drained", exp_q.size(), 32'd0);
        chk("rd_valid_count", n_valid, exp_valid);
        chk("final_busy", {31'd0, rx_if.busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
